// File: rtl/signal_capture_bram_pkg.sv
// Shared constants and state encoding for the capture stage.
// Build option CAPTURE_ZERO_CROSS_TRIGGER_EN is consumed in signal_capture_bram.
package signal_capture_bram_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_ADDR_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    // Rising zero crossing from sign bits: previous sample negative, current non-negative.
    function automatic logic rising_zero_cross(input logic prev_sign, input logic cur_sign);
        return prev_sign & ~cur_sign;
    endfunction

endpackage

// File: rtl/signal_capture_bram_bram_sdp.sv
// Generic simple-dual-port RAM: one write port, one registered read port, read-first.
// The array itself has no reset so synthesis maps it onto block RAM.
module bram_sdp #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [NB_ADDR-1:0] waddr,
    input  logic [NB_DATA-1:0] wdata,
    input  logic [NB_ADDR-1:0] raddr,
    output logic [NB_DATA-1:0] rdata
);

    logic [NB_DATA-1:0] mem [0:(1<<NB_ADDR)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; a same-address write is seen next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/signal_capture_bram.sv
// Records one window of 2**NB_ADDR signed samples into block RAM on i_run.
// Define CAPTURE_ZERO_CROSS_TRIGGER_EN to wait for a rising zero crossing before capturing.
module signal_capture_bram
    import signal_capture_bram_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic signed [NB_DATA-1:0] i_data,
    input  logic                      i_valid,
    input  logic                      i_run,
    input  logic        [NB_ADDR-1:0] i_rd_addr,
    output logic signed [NB_DATA-1:0] o_rd_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic          [NB_ADDR:0] o_count
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

    cap_state_t         state_reg, state_next;
    logic [NB_ADDR-1:0] wr_addr_reg, wr_addr_next;
    logic [NB_ADDR:0]   count_reg, count_next;
    logic               wr_en;
`ifdef CAPTURE_ZERO_CROSS_TRIGGER_EN
    logic signed [NB_DATA-1:0] prev_reg, prev_next;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg   <= ST_IDLE;
            wr_addr_reg <= '0;
            count_reg   <= '0;
`ifdef CAPTURE_ZERO_CROSS_TRIGGER_EN
            prev_reg    <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            wr_addr_reg <= wr_addr_next;
            count_reg   <= count_next;
`ifdef CAPTURE_ZERO_CROSS_TRIGGER_EN
            prev_reg    <= prev_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        wr_addr_next = wr_addr_reg;
        count_next   = count_reg;
        wr_en        = 1'b0;
`ifdef CAPTURE_ZERO_CROSS_TRIGGER_EN
        prev_next    = prev_reg;
`endif
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (i_run) begin
`ifdef CAPTURE_ZERO_CROSS_TRIGGER_EN
                    state_next = ST_ARMED;
                    prev_next  = '0;
`else
                    state_next = ST_CAPTURE;
`endif
                    wr_addr_next = '0;
                    count_next   = '0;
                end
            end
`ifdef CAPTURE_ZERO_CROSS_TRIGGER_EN
            ST_ARMED: begin
                if (i_valid) begin
                    prev_next = i_data;
                    wr_en     = rising_zero_cross(prev_reg[NB_DATA-1], i_data[NB_DATA-1]);
                end
            end
`endif
            ST_CAPTURE: begin
                wr_en = i_valid;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The triggering sample and every capture sample share this write path.
        if (wr_en) begin
            wr_addr_next = wr_addr_reg + NB_ADDR'(1);
            count_next   = count_reg + (NB_ADDR+1)'(1);
            state_next   = (wr_addr_reg == LAST_ADDR) ? ST_DONE : ST_CAPTURE;
        end
    end

    assign o_busy  = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);
    assign o_done  = (state_reg == ST_DONE);
    assign o_count = count_reg;

    bram_sdp #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_bram (
        .clk   (i_clock),
        .rst_n (i_reset),
        .we    (wr_en),
        .waddr (wr_addr_reg),
        .wdata (i_data),
        .raddr (i_rd_addr),
        .rdata (o_rd_data)
    );

endmodule

// File: tb/tb_signal_capture_bram.sv
// Bench for signal_capture_bram with a 16-entry window; read data checked through a scoreboard queue.
// Tests 2-5 target the default build, the trigger test the CAPTURE_ZERO_CROSS_TRIGGER_EN build.
module tb_signal_capture_bram;

    localparam int NB_DATA = 8;
    localparam int NB_ADDR = 4;
    localparam int DEPTH   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      i_reset;
    logic signed [NB_DATA-1:0] i_data;
    logic                      i_valid;
    logic                      i_run;
    logic        [NB_ADDR-1:0] i_rd_addr;
    logic signed [NB_DATA-1:0] o_rd_data;
    logic                      o_busy;
    logic                      o_done;
    logic          [NB_ADDR:0] o_count;

    signal_capture_bram #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
        .i_clock   (clk),
        .i_reset   (i_reset),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .i_run     (i_run),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_count   (o_count)
    );

    typedef struct {
        bit               chk;
        logic [NB_DATA-1:0] val;
    } rd_exp_t;

    rd_exp_t rdq[$];
    rd_exp_t e;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural reference: 0 idle, 1 armed, 2 capture, 3 done.
    int                 m_state;
    int                 m_wa;
    int                 m_cnt;
    logic signed [7:0]  m_prev;
    logic [7:0]         m_mem [DEPTH];
    bit                 m_known [DEPTH];

    function automatic bit m_busy();
        return (m_state == 1) || (m_state == 2);
    endfunction

    task automatic m_write();
        m_mem[m_wa]   = i_data;
        m_known[m_wa] = 1'b1;
        m_wa++;
        m_cnt++;
        m_state = (m_cnt == DEPTH) ? 3 : 2;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_wa    = 0;
        m_cnt   = 0;
        m_prev  = 0;
        rdq.delete();
    endtask

    // One clock: push expected read data (pre-edge, read-first), advance model, settle.
    task automatic step();
        rd_exp_t x;
        x.chk = m_known[i_rd_addr];
        x.val = m_mem[i_rd_addr];
        rdq.push_back(x);
        case (m_state)
            0, 3: if (i_run) begin
`ifdef CAPTURE_ZERO_CROSS_TRIGGER_EN
                m_state = 1;
`else
                m_state = 2;
`endif
                m_wa = 0; m_cnt = 0; m_prev = 0;
            end
            1: if (i_valid) begin
                if (m_prev < 0 && i_data >= 0) m_write();
                m_prev = i_data;
            end
            2: if (i_valid) m_write();
            default: ;
        endcase
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        i_reset = 1'b0; i_run = 1'b0; i_valid = 1'b0;
        @(posedge clk); #1;
        model_reset();
        i_reset = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_run = 1'b0; i_valid = 1'b0; i_data = '0; i_rd_addr = '0;
        repeat (10) @(posedge clk);
        #1;
        tests_run += 4;
        if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", o_busy); end
        if (o_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", o_done); end
        if (o_count !== '0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", o_count); end
        if (o_rd_data !== '0) begin tests_failed++; $display("FAIL reset_rd got %0d want 0", o_rd_data); end
        model_reset();
        i_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1; i_data = 8'(i * 3 - 5); i_rd_addr = 4'(i);
            step();
            e = rdq.pop_front();
            tests_run += 2;
            if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy cyc %0d got %b want 0", i, o_busy); end
            if (o_count !== '0) begin tests_failed++; $display("FAIL idle_count cyc %0d got %0d want 0", i, o_count); end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic_capture();
        int busy_cyc = 0;
        i_rd_addr = '0; i_valid = 1'b1; i_run = 1'b1; i_data = '0;
        step(); e = rdq.pop_front(); busy_cyc += int'(o_busy);
        i_run = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            i_data = 8'(k - 8);
            step(); e = rdq.pop_front(); busy_cyc += int'(o_busy);
            tests_run += 3;
            if (o_busy !== m_busy()) begin tests_failed++; $display("FAIL cap_busy k %0d got %b want %b", k, o_busy, m_busy()); end
            if (o_done !== (m_state == 3)) begin tests_failed++; $display("FAIL cap_done k %0d got %b want %b", k, o_done, m_state == 3); end
            if (o_count !== 5'(m_cnt)) begin tests_failed++; $display("FAIL cap_count k %0d got %0d want %0d", k, o_count, m_cnt); end
        end
        tests_run += 2;
        if (busy_cyc != DEPTH) begin tests_failed++; $display("FAIL cap_busy_len got %0d want %0d", busy_cyc, DEPTH); end
        if (o_done !== 1'b1 || o_count !== 5'd16) begin tests_failed++; $display("FAIL cap_final done %b count %0d want 1 16", o_done, o_count); end
        i_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            i_rd_addr = 4'(k);
            step(); e = rdq.pop_front();
            tests_run++;
            if (o_rd_data !== 8'(k - 8)) begin tests_failed++; $display("FAIL ramp_rd addr %0d got %0d want %0d", k, o_rd_data, k - 8); end
        end
        $display("[TB] test_basic_capture done");
    endtask

    task automatic test_gapped_valid();
        int cyc = 0;
        i_run = 1'b1; i_valid = 1'b0;
        step(); e = rdq.pop_front();
        i_run = 1'b0;
        while (!o_done && cyc < 64) begin
            i_valid = (cyc % 2 == 1);
            i_data  = 8'(32 + m_cnt);
            step(); e = rdq.pop_front();
            tests_run++;
            if (o_count !== 5'(m_cnt)) begin tests_failed++; $display("FAIL gap_count cyc %0d got %0d want %0d", cyc, o_count, m_cnt); end
            cyc++;
        end
        tests_run += 2;
        if (!o_done) begin tests_failed++; $display("FAIL gap_timeout got done %b want 1", o_done); end
        if (cyc != 32) begin tests_failed++; $display("FAIL gap_len got %0d want 32", cyc); end
        i_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            i_rd_addr = 4'(k);
            step(); e = rdq.pop_front();
            tests_run++;
            if (o_rd_data !== 8'(32 + k)) begin tests_failed++; $display("FAIL gap_rd addr %0d got %0d want %0d", k, o_rd_data, 32 + k); end
        end
        $display("[TB] test_gapped_valid done");
    endtask

    task automatic test_mid_capture();
        int  cyc  = 0;
        bit  sent = 1'b0;
        i_run = 1'b1; i_valid = 1'b1; i_rd_addr = '0;
        step(); e = rdq.pop_front();
        i_run = 1'b0;
        while (!o_done && cyc < 64) begin
            i_run  = (o_count == 5'd5) && !sent;
            sent   = sent | i_run;
            i_data = 8'(48 + m_cnt);
            step(); e = rdq.pop_front();
            tests_run++;
            if (o_count !== 5'(m_cnt)) begin tests_failed++; $display("FAIL rerun_count cyc %0d got %0d want %0d", cyc, o_count, m_cnt); end
            cyc++;
        end
        i_run = 1'b0;
        tests_run++;
        if (o_done !== 1'b1 || o_count !== 5'd16) begin tests_failed++; $display("FAIL rerun_final done %b count %0d want 1 16", o_done, o_count); end

        i_run = 1'b1;
        step(); e = rdq.pop_front();
        i_run = 1'b0; cyc = 0;
        while (o_count != 5'd7 && cyc < 32) begin
            i_data = 8'(64 + m_cnt);
            step(); e = rdq.pop_front();
            cyc++;
        end
        i_reset = 1'b0;
        #1;
        tests_run += 4;
        if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL arst_busy got %b want 0", o_busy); end
        if (o_count !== '0) begin tests_failed++; $display("FAIL arst_count got %0d want 0", o_count); end
        if (o_done !== 1'b0) begin tests_failed++; $display("FAIL arst_done got %b want 0", o_done); end
        if (o_rd_data !== '0) begin tests_failed++; $display("FAIL arst_rd got %0d want 0", o_rd_data); end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b1; i_run = 1'b1;
        step(); e = rdq.pop_front();
        i_run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_data = 8'(96 + i);
            step(); e = rdq.pop_front();
        end
        i_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_rd_addr = 4'(k);
            step(); e = rdq.pop_front();
            if (e.chk) begin
                tests_run++;
                if (o_rd_data !== e.val) begin tests_failed++; $display("FAIL restart_rd addr %0d got %0h want %0h", k, o_rd_data, e.val); end
            end
        end
        $display("[TB] test_mid_capture done");
    endtask

    task automatic test_read_during_write();
        bit hit, was_hit;
        pulse_reset();
        i_run = 1'b1; i_valid = 1'b1; i_data = 8'h11; i_rd_addr = 4'd3;
        step(); e = rdq.pop_front();
        i_run = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin step(); e = rdq.pop_front(); end
        i_run = 1'b1; i_data = 8'h55;
        step(); e = rdq.pop_front();
        i_run = 1'b0; was_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            hit = (m_state == 2) && (m_wa == 3);
            step(); e = rdq.pop_front();
            if (e.chk) begin
                tests_run++;
                if (o_rd_data !== e.val) begin tests_failed++; $display("FAIL rdw_rd k %0d got %0h want %0h", k, o_rd_data, e.val); end
            end
            if (hit) begin
                tests_run++;
                if (o_rd_data !== 8'h11) begin tests_failed++; $display("FAIL rdw_old got %0h want 11", o_rd_data); end
            end
            if (was_hit) begin
                tests_run++;
                if (o_rd_data !== 8'h55) begin tests_failed++; $display("FAIL rdw_new got %0h want 55", o_rd_data); end
            end
            was_hit = hit;
        end
        $display("[TB] test_read_during_write done");
    endtask

    task automatic test_zero_cross_trigger();
        int seq [6] = '{-3, -1, -2, 2, 4, 5};
        pulse_reset();
        i_run = 1'b1; i_valid = 1'b1; i_data = 8'sd1; i_rd_addr = '0;
        step(); e = rdq.pop_front();
        i_run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_data = 8'(seq[i]);
            step(); e = rdq.pop_front();
            tests_run += 2;
            if (o_busy !== 1'b1) begin tests_failed++; $display("FAIL zc_busy i %0d got %b want 1", i, o_busy); end
            if (o_count !== 5'(m_cnt)) begin tests_failed++; $display("FAIL zc_count i %0d got %0d want %0d", i, o_count, m_cnt); end
        end
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_rd_addr = 4'(k);
            step(); e = rdq.pop_front();
            tests_run++;
            if (o_rd_data !== 8'(seq[k + 3])) begin tests_failed++; $display("FAIL zc_rd addr %0d got %0d want %0d", k, o_rd_data, seq[k + 3]); end
        end
        pulse_reset();
        i_run = 1'b1; i_valid = 1'b1;
        step(); e = rdq.pop_front();
        i_run = 1'b0;
        for (int i = 0; i < 40; i++) begin
            i_data = -8'($urandom_range(1, 100));
            step(); e = rdq.pop_front();
            tests_run++;
            if (o_busy !== 1'b1 || o_count !== '0) begin tests_failed++; $display("FAIL zc_hold i %0d busy %b count %0d want 1 0", i, o_busy, o_count); end
        end
        $display("[TB] test_zero_cross_trigger done");
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin m_known[i] = 1'b0; m_mem[i] = '0; end
        test_reset();
`ifdef CAPTURE_ZERO_CROSS_TRIGGER_EN
        test_zero_cross_trigger();
`else
        test_basic_capture();
        test_gapped_valid();
        test_mid_capture();
        test_read_during_write();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
